// File: rtl/sd_block_receiver.sv
// sd_block_receiver: hunts for the start token in the SPI response stream,
// stores one data block in a local RAM and checks its trailing CRC16.
module sd_block_receiver #(
   parameter int         BLOCK_BYTES   = 512,
   parameter logic [7:0] TOKEN         = 8'hFE,
   parameter int         TIMEOUT_BYTES = 1024,
   parameter int         AW            = $clog2(BLOCK_BYTES)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          RES_STB,
   input  logic [7:0]    RES_DATA,
   output logic          RES_ACK,
   input  logic          START,
   output logic          BUSY,
   output logic          DONE,
   output logic [1:0]    STATUS,
   output logic [7:0]    ERR_TOKEN,
   input  logic [AW-1:0] RD_ADDR,
   output logic [7:0]    RD_DATA
);

   typedef enum logic [2:0] {
      IDLE, HUNT, DATA, CRC_HI, CRC_LO, FIN
   } state_t;

   localparam logic [15:0] LAST = 16'(BLOCK_BYTES - 1);
   localparam logic [15:0] TMO  = 16'(TIMEOUT_BYTES);

   function automatic logic [15:0] crc_step(
      input logic [15:0] c,
      input logic [7:0]  b
   );
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n, cnt_inc;
   logic [15:0] crc, crc_n;
   logic [7:0]  crc_hi, crc_hi_n;
   logic [1:0]  status, status_n;
   logic [7:0]  err, err_n;
   logic        wr_en, xfer, arm, tok_err;
   logic [7:0]  mem [BLOCK_BYTES];

   assign RES_ACK   = RES_STB;
   assign xfer      = RES_STB;
   assign BUSY      = state inside {HUNT, DATA, CRC_HI, CRC_LO};
   assign DONE      = (state == FIN);
   assign STATUS    = status;
   assign ERR_TOKEN = err;
   assign cnt_inc   = cnt + 16'd1;
   assign arm       = START && (state == IDLE || state == FIN);
   assign tok_err   = (RES_DATA[7:4] == 4'h0) && (RES_DATA != 8'h00);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      crc_n    = crc;
      crc_hi_n = crc_hi;
      status_n = status;
      err_n    = err;
      wr_en    = 1'b0;
      unique case (state)
         IDLE, FIN: begin
            state_n = IDLE;
            if (arm) begin
               state_n = HUNT;
               cnt_n   = '0;
               crc_n   = '0;
               err_n   = '0;
            end
         end
         HUNT: if (xfer) begin
            cnt_n = cnt_inc;
            priority case (1'b1)
               RES_DATA == TOKEN: begin
                  state_n = DATA;
                  cnt_n   = '0;
               end
               tok_err: begin
                  err_n    = RES_DATA;
                  status_n = 2'b11;
                  state_n  = FIN;
               end
               cnt_inc == TMO: begin
                  status_n = 2'b10;
                  state_n  = FIN;
               end
               default: ;
            endcase
         end
         DATA: if (xfer) begin
            wr_en = 1'b1;
            crc_n = crc_step(crc, RES_DATA);
            cnt_n = cnt_inc;
            if (cnt == LAST) state_n = CRC_HI;
         end
         CRC_HI: if (xfer) begin
            crc_hi_n = RES_DATA;
            state_n  = CRC_LO;
         end
         CRC_LO: if (xfer) begin
            status_n = ({crc_hi, RES_DATA} == crc) ? 2'b00 : 2'b01;
            state_n  = FIN;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         crc    <= '0;
         crc_hi <= '0;
         status <= '0;
         err    <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         crc    <= crc_n;
         crc_hi <= crc_hi_n;
         status <= status_n;
         err    <= err_n;
      end
   end

   // Block RAM: contents survive reset, so no reset on the array.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[cnt[AW-1:0]] <= RES_DATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) RD_DATA <= '0;
      else     RD_DATA <= mem[RD_ADDR];
   end

endmodule

// File: tb/tb_sd_block_receiver.sv
// Bench for sd_block_receiver: scenario table, reset sequence and random
// streams checked against a stream-level reference model.
module tb_sd_block_receiver;

   localparam int         BB  = 512;
   localparam int         AW  = 9;
   localparam int         TMO = 1024;
   localparam logic [7:0] TOK = 8'hFE;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          RES_STB = 1'b0;
   logic [7:0]    RES_DATA = 8'h00;
   logic          RES_ACK;
   logic          START = 1'b0;
   logic          BUSY, DONE;
   logic [1:0]    STATUS;
   logic [7:0]    ERR_TOKEN;
   logic [AW-1:0] RD_ADDR = '0;
   logic [7:0]    RD_DATA;

   sd_block_receiver #(
      .BLOCK_BYTES(BB), .TOKEN(TOK), .TIMEOUT_BYTES(TMO), .AW(AW)
   ) dut (
      .CLK(CLK), .RST(RST), .RES_STB(RES_STB), .RES_DATA(RES_DATA),
      .RES_ACK(RES_ACK), .START(START), .BUSY(BUSY), .DONE(DONE),
      .STATUS(STATUS), .ERR_TOKEN(ERR_TOKEN), .RD_ADDR(RD_ADDR),
      .RD_DATA(RD_DATA)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          pre_ff;
      int          lead;
      bit          fill_ff;
      bit          fixed_crc;
      logic [15:0] crc_val;
      logic [1:0]  exp_st;
      logic [7:0]  exp_err;
   } vec_t;

   int         total = 0;
   int         bad = 0;
   int         done_cnt = 0;
   int         side_bad = 0;
   logic [7:0] stim[$];
   logic [7:0] mbuf[BB];
   logic [1:0] prev_st = 2'b00;
   vec_t       vec[8];

   always @(posedge CLK) if (DONE) done_cnt <= done_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Bit-serial CRC-CCITT (poly 0x1021, init 0) over stim[first +: len].
   function automatic logic [15:0] ref_crc(input int first, input int len);
      logic [15:0] r;
      logic        fb;
      r = 16'h0000;
      for (int i = 0; i < len; i++)
         for (int k = 7; k >= 0; k--) begin
            fb = r[15] ^ stim[first+i][k];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
         end
      return r;
   endfunction

   // Interprets the whole byte stream following START.
   task automatic model(output logic [1:0] st, output logic [7:0] et);
      int          tok;
      logic [15:0] rx;
      tok = -1;
      st  = 2'b00;
      et  = 8'h00;
      for (int i = 0; i < stim.size(); i++) begin
         if (stim[i] == TOK) begin
            tok = i;
            break;
         end
         if (stim[i] != 8'h00 && stim[i] < 8'h10) begin
            st = 2'b11;
            et = stim[i];
            return;
         end
         if (i + 1 == TMO) begin
            st = 2'b10;
            return;
         end
      end
      if (tok < 0) return;
      for (int j = 0; j < BB; j++) mbuf[j] = stim[tok+1+j];
      rx = {stim[tok+BB+1], stim[tok+BB+2]};
      st = (rx == ref_crc(tok + 1, BB)) ? 2'b00 : 2'b01;
   endtask

   task automatic send(input logic [7:0] b, input int gap, input bit st);
      repeat (gap) begin
         @(negedge CLK);
         RES_STB = 1'b0;
         START   = 1'b0;
         #1 if (RES_ACK !== 1'b0) side_bad++;
      end
      @(negedge CLK);
      RES_STB  = 1'b1;
      RES_DATA = b;
      START    = st;
      #1 if (RES_ACK !== 1'b1) side_bad++;
      @(posedge CLK);
      #1;
   endtask

   task automatic rd(input int a, input logic [7:0] e, input string name);
      @(negedge CLK);
      RD_ADDR = a[AW-1:0];
      @(posedge CLK);
      #1 chk(name, {24'h0, RD_DATA}, {24'h0, e});
   endtask

   task automatic run(input int gapmax, input bit coinc, input bit mid,
                      input logic [1:0] est, input logic [7:0] eet,
                      input string tag);
      int n, d0, busy_low;
      n = stim.size();
      d0 = done_cnt;
      busy_low = 0;
      @(negedge CLK);
      START    = 1'b1;
      RES_STB  = coinc;
      RES_DATA = TOK;
      #1 chk($sformatf("%s/busy_pre", tag), BUSY, 0);
      @(posedge CLK);
      #1;
      chk($sformatf("%s/busy_rise", tag), BUSY, 1);
      chk($sformatf("%s/err_clear", tag), ERR_TOKEN, 0);
      chk($sformatf("%s/status_hold", tag), STATUS, prev_st);
      for (int i = 0; i < n; i++) begin
         send(stim[i], gapmax > 0 ? $urandom_range(0, gapmax) : 0,
              mid && (i == n / 2));
         if (i < n - 1 && BUSY !== 1'b1) busy_low++;
      end
      chk($sformatf("%s/early_done", tag), done_cnt, d0);
      chk($sformatf("%s/done", tag), DONE, 1);
      chk($sformatf("%s/busy_fall", tag), BUSY, 0);
      chk($sformatf("%s/status", tag), STATUS, est);
      chk($sformatf("%s/err_token", tag), ERR_TOKEN, eet);
      chk($sformatf("%s/busy_held", tag), busy_low, 0);
      @(negedge CLK);
      RES_STB = 1'b0;
      START   = 1'b0;
      @(posedge CLK);
      #1;
      chk($sformatf("%s/done_pulse", tag), DONE, 0);
      chk($sformatf("%s/done_once", tag), done_cnt, d0 + 1);
      prev_st = est;
   endtask

   task automatic gen_random();
      int          pre, kind, d0;
      logic [15:0] c;
      stim.delete();
      pre = $urandom_range(0, 20);
      for (int i = 0; i < pre; i++)
         stim.push_back(($urandom % 3 == 0) ?
                        8'($urandom_range(16, 253)) : 8'hFF);
      kind = $urandom % 4;
      if (kind < 2) begin
         stim.push_back(TOK);
         d0 = stim.size();
         for (int j = 0; j < BB; j++) stim.push_back(8'($urandom));
         c = ref_crc(d0, BB);
         if (kind == 1) c = c ^ 16'($urandom_range(1, 65535));
         stim.push_back(c[15:8]);
         stim.push_back(c[7:0]);
      end else if (kind == 2) begin
         stim.push_back(8'($urandom_range(1, 15)));
      end else begin
         while (stim.size() < TMO) stim.push_back(8'hFF);
      end
   endtask

   initial begin
      logic [1:0]  mst;
      logic [7:0]  met;
      logic [15:0] c;
      int          d0, a;

      vec[0] = '{3,    'hFE, 0, 0, 16'h0000, 2'b00, 8'h00};
      vec[1] = '{0,    'hFE, 1, 1, 16'h7FA1, 2'b00, 8'h00};
      vec[2] = '{0,    'hFE, 1, 1, 16'h7FA0, 2'b01, 8'h00};
      vec[3] = '{1024, -1,   0, 0, 16'h0000, 2'b10, 8'h00};
      vec[4] = '{1023, 'hFE, 1, 1, 16'h7FA1, 2'b00, 8'h00};
      vec[5] = '{2,    'h05, 0, 0, 16'h0000, 2'b11, 8'h05};
      vec[6] = '{0,    'h0F, 0, 0, 16'h0000, 2'b11, 8'h0F};
      vec[7] = '{1,    'h01, 0, 0, 16'h0000, 2'b11, 8'h01};

      repeat (2) @(negedge CLK);
      chk("rst/busy", BUSY, 0);
      chk("rst/done", DONE, 0);
      chk("rst/status", STATUS, 0);
      chk("rst/err_token", ERR_TOKEN, 0);
      chk("rst/rd_data", RD_DATA, 0);
      chk("rst/ack_lo", RES_ACK, 0);
      RES_STB = 1'b1;
      #1 chk("rst/ack_hi", RES_ACK, 1);
      RES_STB = 1'b0;
      @(negedge CLK);
      RST = 1'b0;

      for (int e = 0; e < 8; e++) begin
         stim.delete();
         repeat (vec[e].pre_ff) stim.push_back(8'hFF);
         if (vec[e].lead >= 0) stim.push_back(8'(vec[e].lead));
         if (vec[e].lead == int'(TOK)) begin
            d0 = stim.size();
            for (int j = 0; j < BB; j++)
               stim.push_back(vec[e].fill_ff ? 8'hFF : 8'(j));
            c = vec[e].fixed_crc ? vec[e].crc_val : ref_crc(d0, BB);
            stim.push_back(c[15:8]);
            stim.push_back(c[7:0]);
         end
         model(mst, met);
         run(0, 0, 0, vec[e].exp_st, vec[e].exp_err,
             $sformatf("vec%0d", e));
         if (e == 0) begin
            rd(5, 8'h05, "vec0/rd5");
            rd(300, 8'h2C, "vec0/rd300");
         end
         a = (e * 37 + 11) % BB;
         rd(a, mbuf[a], $sformatf("vec%0d/rd", e));
      end

      stim.delete();
      stim.push_back(8'hFF);
      stim.push_back(8'hFF);
      stim.push_back(TOK);
      for (int j = 0; j < 100; j++) stim.push_back(8'(j * 3 + 1));
      d0 = done_cnt;
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      #1;
      foreach (stim[i]) send(stim[i], 0, 0);
      for (int j = 0; j < 100; j++) mbuf[j] = stim[3+j];
      @(negedge CLK);
      RES_STB = 1'b0;
      RST = 1'b1;
      #1;
      chk("midrst/busy", BUSY, 0);
      chk("midrst/done", DONE, 0);
      chk("midrst/status", STATUS, 0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("midrst/no_done", done_cnt, d0);
      chk("midrst/idle", BUSY, 0);
      rd(50, mbuf[50], "midrst/partial");
      rd(200, mbuf[200], "midrst/old");
      prev_st = 2'b00;

      stim.delete();
      stim.push_back(TOK);
      for (int j = 0; j < BB; j++) stim.push_back(8'($urandom));
      c = ref_crc(1, BB);
      stim.push_back(c[15:8]);
      stim.push_back(c[7:0]);
      model(mst, met);
      run(0, 0, 0, 2'b00, 8'h00, "post_rst");
      rd(50, mbuf[50], "post_rst/rd");

      for (int r = 0; r < 8; r++) begin
         gen_random();
         model(mst, met);
         run(5, 1'($urandom % 2), 1'($urandom % 2), mst, met,
             $sformatf("rand%0d", r));
         a = $urandom_range(0, BB - 1);
         rd(a, mbuf[a], $sformatf("rand%0d/rd", r));
      end

      chk("ack_follows_stb", side_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
